// File: rtl/v4_peak_detector_pkg.sv
// v4_peak_detector_pkg: shared sample width, detector defaults, FSM states and event record
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

package v4_parameters;
  localparam int K = 4;
  localparam int L = 8;
  localparam int TS_W = 32;
  localparam int DROP_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, RISE, TOP, FALL} state_t;
  // Field "ts" carries the crossing timestamp ("time" is reserved in SystemVerilog)
  typedef struct packed {
    logic signed [package_settings::SIZE_FILTER_DATA-1:0] amp;
    logic [TS_W-1:0] ts;
    logic pileup;
  } event_t;
endpackage

// File: rtl/v4_peak_detector_event_buffer.sv
// v4_event_buffer: one-entry valid/ready event register with saturating drop counter
module v4_event_buffer import v4_parameters::*; #(
  parameter int DATA_W = package_settings::SIZE_FILTER_DATA,
  parameter int TS_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     emit,
  input  logic signed [DATA_W-1:0] amp,
  input  logic [TS_W-1:0]          tstamp,
  input  logic                     pileup,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic [TS_W-1:0]          ev_time,
  output logic                     ev_pileup,
  output logic [DROP_CNT_W-1:0]    drop_cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ev_valid <= 1'b0;
      ev_amp <= '0;
      ev_time <= '0;
      ev_pileup <= 1'b0;
      drop_cnt <= '0;
    end else if (emit && (!ev_valid || ev_ready)) begin
      ev_valid <= 1'b1;
      ev_amp <= amp;
      ev_time <= tstamp;
      ev_pileup <= pileup;
    end else if (emit) begin
      drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
    end else if (ev_ready) begin
      ev_valid <= 1'b0;
    end
endmodule

// File: rtl/v4_peak_detector.sv
// v4_peak_detector: threshold-triggered trapezoid flat-top maximum finder with pile-up flag
module v4_peak_detector import v4_parameters::*; #(
  parameter int K = v4_parameters::K,
  parameter int L = v4_parameters::L,
  parameter int DATA_W = package_settings::SIZE_FILTER_DATA,
  parameter int TS_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] thr,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic [TS_W-1:0]          ev_time,
  output logic                     ev_pileup,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic                     busy
);
  localparam int CW = $clog2(L + 2);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TS_W-1:0] ts, t0, t0_nx;
  logic signed [DATA_W-1:0] mx, mx_nx;
  logic above, emit;
  assign above = in_data > thr;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    t0_nx = t0;
    mx_nx = mx;
    emit = 1'b0;
    case (state)
      IDLE: if (above) begin
        state_nx = RISE;
        cnt_nx = '0;
        t0_nx = ts;
      end
      RISE: begin
        cnt_nx = cnt + 1'b1;
        if (!above) state_nx = IDLE;
        else if (cnt == CW'(K - 1)) begin
          state_nx = TOP;
          cnt_nx = '0;
          mx_nx = in_data;
        end
      end
      TOP: begin
        mx_nx = in_data > mx ? in_data : mx;
        cnt_nx = cnt == CW'(L - K - 1) ? '0 : cnt + 1'b1;
        state_nx = cnt == CW'(L - K - 1) ? FALL : TOP;
      end
      FALL: begin
        // Saturating at K+1 is enough to tell a pile-up from a normal fall
        cnt_nx = cnt == CW'(K + 1) ? cnt : cnt + 1'b1;
        if (!above) begin
          state_nx = IDLE;
          emit = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      ts <= '0;
      t0 <= '0;
      mx <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ts <= ts + 1'b1;
      t0 <= t0_nx;
      mx <= mx_nx;
    end
  v4_event_buffer #(.DATA_W(DATA_W), .TS_W(TS_W)) u_buf (
    .clk(clk),
    .reset(reset),
    .emit(emit),
    .amp(mx),
    .tstamp(t0),
    .pileup(cnt > CW'(K)),
    .ev_ready(ev_ready),
    .ev_valid(ev_valid),
    .ev_amp(ev_amp),
    .ev_time(ev_time),
    .ev_pileup(ev_pileup),
    .drop_cnt(drop_cnt)
  );
endmodule

// File: tb/tb_v4_peak_detector.sv
// tb_v4_peak_detector: directed pulses with a queue scoreboard checked on each accepted event
module tb_v4_peak_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] thr = 16'sd100;
  logic ev_valid, ev_ready = 1'b0, ev_pileup, busy;
  logic signed [15:0] ev_amp;
  logic [31:0] ev_time;
  logic [7:0] drop_cnt;
  typedef struct {int amp; longint t; bit p;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  longint edges = 0, t0 = 0;

  v4_peak_detector #(.K(4), .L(8), .DATA_W(16), .TS_W(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .thr(thr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_amp(ev_amp),
    .ev_time(ev_time), .ev_pileup(ev_pileup), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  // Clock edges seen since reset release: the timestamp the next sample will carry
  always @(posedge clk or negedge reset)
    if (!reset) edges <= 0;
    else edges <= edges + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int v, input bit r);
    @(negedge clk);
    in_data = 16'(v);
    ev_ready = r;
  endtask

  task automatic pulse(input int f0, f1, f2, f3, input int fall_v, input int fall_n, input bit r);
    @(negedge clk);
    t0 = edges;
    in_data = 16'sd250;
    ev_ready = r;
    send(500, r); send(750, r); send(1000, r);
    send(f0, r); send(f1, r); send(f2, r); send(f3, r);
    if (fall_n == 0) begin
      send(750, r); send(500, r); send(250, r);
    end else
      for (int i = 0; i < fall_n; i++) send(fall_v, r);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset && ev_valid && ev_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got amp %0d time %0d, expected none", ev_amp, ev_time);
      end else begin
        e = q.pop_front();
        chk("ev_amp", longint'(ev_amp), e.amp);
        chk("ev_time", longint'(ev_time), e.t);
        chk("ev_pileup", longint'(ev_pileup), longint'(e.p));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", ev_valid, 0); chk("rst_amp", ev_amp, 0); chk("rst_time", ev_time, 0);
    chk("rst_pileup", ev_pileup, 0); chk("rst_drop", drop_cnt, 0); chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) send(0, 1);
    // clean pulse: 250 sample carries ts=5
    q.push_back('{1010, 5, 0});
    pulse(1000, 1000, 1010, 1000, 0, 0, 1);
    send(0, 1);
    #1 chk("t1_valid_before", ev_valid, 0);
    send(0, 1);
    #1 chk("t1_valid_after", ev_valid, 1);
    repeat (3) send(0, 1);
    // noise spike
    send(200, 1); send(200, 1);
    #1 chk("t2_busy_high", busy, 1);
    send(0, 1); send(0, 1);
    #1 chk("t2_busy_low", busy, 0);
    chk("t2_drop", drop_cnt, 0);
    repeat (3) send(0, 1);
    // pile-up
    pulse(1000, 1000, 1000, 1000, 600, 10, 1);
    q.push_back('{1000, t0, 1});
    send(0, 1);
    repeat (3) send(0, 1);
    // backpressure drop
    pulse(1000, 1000, 1000, 1000, 0, 0, 0);
    q.push_back('{1000, t0, 0});
    send(0, 0);
    repeat (3) send(0, 0);
    pulse(2000, 2000, 2000, 2000, 0, 0, 0);
    send(0, 0);
    send(0, 0);
    #1 chk("t4_valid", ev_valid, 1);
    chk("t4_amp", ev_amp, 1000);
    chk("t4_drop", drop_cnt, 1);
    send(0, 1);
    send(0, 0);
    #1 chk("t4_valid_fall", ev_valid, 0);
    repeat (2) send(0, 0);
    // simultaneous accept and emit
    pulse(1000, 1000, 1000, 1000, 0, 0, 0);
    q.push_back('{1000, t0, 0});
    send(0, 0);
    repeat (3) send(0, 0);
    pulse(2000, 2000, 2000, 2000, 0, 0, 0);
    q.push_back('{2000, t0, 0});
    send(0, 1);
    send(0, 0);
    #1 chk("t5_valid", ev_valid, 1);
    chk("t5_amp", ev_amp, 2000);
    chk("t5_drop", drop_cnt, 1);
    send(0, 1);
    repeat (3) send(0, 0);
    // reset mid-TOP with an event still buffered
    pulse(1000, 1000, 1000, 1000, 0, 0, 0);
    send(0, 0);
    repeat (2) send(0, 0);
    send(250, 0); send(500, 0); send(750, 0); send(1000, 0); send(1000, 0); send(1000, 0);
    @(negedge clk);
    reset = 1'b0;
    in_data = '0;
    #1;
    chk("t6_valid", ev_valid, 0); chk("t6_amp", ev_amp, 0); chk("t6_time", ev_time, 0);
    chk("t6_pileup", ev_pileup, 0); chk("t6_drop", drop_cnt, 0); chk("t6_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ev_ready = 1'b1;
    repeat (10) send(0, 1);
    // ts restarted: 250 sample is the 12th post-release sample, ts=11
    q.push_back('{1000, 11, 0});
    pulse(1000, 1000, 1000, 1000, 0, 0, 1);
    send(0, 1);
    repeat (4) send(0, 1);
    #1 chk("queue_empty", q.size(), 0);
    chk("end_valid", ev_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
